// File: rtl/pc_seq_pkg.sv
// Shared definitions for the PC fetch sequencer: datapath width,
// instruction size, FSM state encoding and an alignment helper.
package pc_seq_pkg;

   localparam int unsigned XLEN = 32;
   localparam logic [XLEN-1:0] INSTR_BYTES = 32'd4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_REQ   = 2'd1,
      ST_ISSUE = 2'd2,
      ST_TRAP  = 2'd3
   } state_t;

   // True when an address is not on a 4-byte instruction boundary.
   function automatic logic misaligned(input logic [XLEN-1:0] addr);
      return addr[1:0] != 2'b00;
   endfunction

endpackage

// File: rtl/pc_next_adder.sv
// Combinational next-PC generator: sequential step of one instruction or a
// taken-branch byte offset. The sum wraps modulo 2^32 by construction.
module pc_next_adder
   import pc_seq_pkg::*;
(
   input  logic [XLEN-1:0] pc,
   input  logic            branch_taken,
   input  logic [XLEN-1:0] branch_offset,
   output logic [XLEN-1:0] next_pc
);

   // Select the increment and add; carry out is intentionally dropped.
   always_comb begin
      next_pc = pc + (branch_taken ? branch_offset : INSTR_BYTES);
   end

endmodule

// File: rtl/pc_fetch_sequencer.sv
// PC fetch sequencer: requests one instruction word at the current PC,
// holds it for a downstream handshake, then advances the PC (sequential or
// branch) and counts the retired instruction.
// Optional feature: define PC_TRAP_EN to trap on a misaligned next-PC
// (pc takes the bad target, trap latches high, FSM parks in ST_TRAP until
// reset). Without it, trap is tied low and ST_TRAP is never entered.
module pc_fetch_sequencer
   import pc_seq_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
   input  logic            clock,
   input  logic            Reset,
   input  logic            start,
   input  logic            halt,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_ack,
   input  logic [XLEN-1:0] imem_rdata,
   output logic            instr_valid,
   output logic [XLEN-1:0] instr,
   input  logic            instr_ready,
   input  logic            branch_taken,
   input  logic [XLEN-1:0] branch_offset,
   output logic [XLEN-1:0] pc,
   output logic [XLEN-1:0] instret,
   output logic            trap
);

   state_t          state_reg;
   state_t          state_next;
   logic [XLEN-1:0] pc_reg;
   logic [XLEN-1:0] instr_reg;
   logic [XLEN-1:0] instret_reg;
   logic [XLEN-1:0] next_pc;
   logic            handshake;
   logic            load_instr;
   logic            trap_hit;

   pc_next_adder u_next (
      .pc            (pc_reg),
      .branch_taken  (branch_taken),
      .branch_offset (branch_offset),
      .next_pc       (next_pc)
   );

`ifdef PC_TRAP_EN
   assign trap_hit = misaligned(next_pc);
`else
   assign trap_hit = 1'b0;
`endif

   // State register; reset abandons any transaction in flight.
   always_ff @(posedge clock or negedge Reset) begin
      if (!Reset) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state and handshake decode; request and valid come straight from
   // the state, so they are mutually exclusive and drop at once on reset.
   always_comb begin
      state_next  = state_reg;
      imem_req    = 1'b0;
      instr_valid = 1'b0;
      handshake   = 1'b0;
      load_instr  = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (start) begin
               state_next = ST_REQ;
            end
         end
         ST_REQ: begin
            imem_req = 1'b1;
            if (imem_ack) begin
               load_instr = 1'b1;
               state_next = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            instr_valid = 1'b1;
            if (instr_ready) begin
               handshake = 1'b1;
               if (trap_hit) begin
                  state_next = ST_TRAP;
               end else if (halt) begin
                  state_next = ST_IDLE;
               end else begin
                  state_next = ST_REQ;
               end
            end
         end
         ST_TRAP: begin
            state_next = ST_TRAP;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // Datapath: capture fetched word on ack, advance PC and retire count on
   // the downstream handshake only.
   always_ff @(posedge clock or negedge Reset) begin
      if (!Reset) begin
         pc_reg      <= RESET_PC;
         instr_reg   <= '0;
         instret_reg <= '0;
      end else begin
         if (load_instr) begin
            instr_reg <= imem_rdata;
         end
         if (handshake) begin
            pc_reg      <= next_pc;
            instret_reg <= instret_reg + 32'd1;
         end
      end
   end

`ifdef PC_TRAP_EN
   logic trap_reg;

   // Sticky trap flag, cleared only by reset.
   always_ff @(posedge clock or negedge Reset) begin
      if (!Reset) begin
         trap_reg <= 1'b0;
      end else if (handshake && trap_hit) begin
         trap_reg <= 1'b1;
      end
   end

   assign trap = trap_reg;
`else
   assign trap = 1'b0;
`endif

   assign imem_addr = pc_reg;
   assign pc        = pc_reg;
   assign instr     = instr_reg;
   assign instret   = instret_reg;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Directed testbench for pc_fetch_sequencer: a table of fetch/retire
// transactions plus hand-written reset, idle and trap sequences.
module tb_pc_fetch_sequencer;

`ifdef PC_TRAP_EN
   localparam bit TRAP_EN = 1'b1;
`else
   localparam bit TRAP_EN = 1'b0;
`endif

   logic        clock;
   logic        Reset;
   logic        start;
   logic        halt;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        instr_valid;
   logic [31:0] instr;
   logic        instr_ready;
   logic        branch_taken;
   logic [31:0] branch_offset;
   logic [31:0] pc;
   logic [31:0] instret;
   logic        trap;

   int checks   = 0;
   int failures = 0;

   pc_fetch_sequencer #(.RESET_PC(32'h0000_0000)) dut (
      .clock         (clock),
      .Reset         (Reset),
      .start         (start),
      .halt          (halt),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_ack      (imem_ack),
      .imem_rdata    (imem_rdata),
      .instr_valid   (instr_valid),
      .instr         (instr),
      .instr_ready   (instr_ready),
      .branch_taken  (branch_taken),
      .branch_offset (branch_offset),
      .pc            (pc),
      .instret       (instret),
      .trap          (trap)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic        start_first;
      logic [31:0] exp_addr;
      int          wait_cyc;
      logic [31:0] rdata;
      int          rdy_dly;
      logic        br;
      logic [31:0] off;
      logic        hlt;
      logic [31:0] exp_pc;
      logic [31:0] exp_instret;
      logic        exp_req;
      logic        exp_trap;
   } vec_t;

   vec_t vecs[8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // One fetch/issue/retire transaction; entered at a negedge with the DUT
   // in IDLE (start_first=1) or REQ.
   task automatic run_vec(input vec_t v, input string tag);
      if (v.start_first) begin
         start = 1'b1;
         @(negedge clock);
         start = 1'b0;
      end
      chk({tag, ".req"}, imem_req, 1'b1);
      chk({tag, ".addr"}, imem_addr, v.exp_addr);
      chk({tag, ".valid_in_req"}, instr_valid, 1'b0);
      repeat (v.wait_cyc) @(negedge clock);
      chk({tag, ".req_held"}, imem_req, 1'b1);
      chk({tag, ".addr_held"}, imem_addr, v.exp_addr);
      imem_ack   = 1'b1;
      imem_rdata = v.rdata;
      @(negedge clock);
      imem_ack   = 1'b0;
      imem_rdata = ~v.rdata;
      chk({tag, ".valid"}, instr_valid, 1'b1);
      chk({tag, ".instr"}, instr, v.rdata);
      chk({tag, ".req_off"}, imem_req, 1'b0);
      for (int k = 0; k < v.rdy_dly; k++) begin
         // Stall with noise on every input that must be ignored in ISSUE.
         start         = 1'b1;
         imem_ack      = 1'b1;
         branch_taken  = 1'b1;
         branch_offset = 32'h0000_0040;
         halt          = 1'b1;
         @(negedge clock);
         chk({tag, ".stall_instr"}, instr, v.rdata);
         chk({tag, ".stall_pc"}, pc, v.exp_addr);
         chk({tag, ".stall_req"}, imem_req, 1'b0);
         chk({tag, ".stall_valid"}, instr_valid, 1'b1);
      end
      start         = 1'b0;
      imem_ack      = 1'b0;
      instr_ready   = 1'b1;
      branch_taken  = v.br;
      branch_offset = v.off;
      halt          = v.hlt;
      @(negedge clock);
      instr_ready   = 1'b0;
      branch_taken  = 1'b0;
      branch_offset = 32'h0;
      halt          = 1'b0;
      chk({tag, ".pc"}, pc, v.exp_pc);
      chk({tag, ".instret"}, instret, v.exp_instret);
      chk({tag, ".valid_clr"}, instr_valid, 1'b0);
      chk({tag, ".next_req"}, imem_req, v.exp_req);
      chk({tag, ".next_addr"}, imem_addr, v.exp_pc);
      chk({tag, ".trap"}, trap, v.exp_trap);
      $display("%s addr=%h instr=%h pc=%h instret=%0d", tag, v.exp_addr, instr, pc, instret);
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, ".req"}, imem_req, 1'b0);
      chk({tag, ".valid"}, instr_valid, 1'b0);
      chk({tag, ".pc"}, pc, 32'h0);
      chk({tag, ".addr"}, imem_addr, 32'h0);
      chk({tag, ".instr"}, instr, 32'h0);
      chk({tag, ".instret"}, instret, 32'h0);
      chk({tag, ".trap"}, trap, 1'b0);
   endtask

   initial begin
      vec_t t0;
      vec_t t1;
      //            start addr          wt rdata          dly br   off            halt exp_pc         instret req   trap
      vecs[0] = '{1'b1, 32'h0000_0000, 3, 32'h0050_0093, 0, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0004, 32'd1, 1'b1, 1'b0};
      vecs[1] = '{1'b0, 32'h0000_0004, 0, 32'h0BAD_F00D, 5, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0008, 32'd2, 1'b1, 1'b0};
      vecs[2] = '{1'b0, 32'h0000_0008, 1, 32'h1234_5678, 0, 1'b1, 32'hFFFF_FFF8, 1'b0, 32'h0000_0000, 32'd3, 1'b1, 1'b0};
      vecs[3] = '{1'b0, 32'h0000_0000, 2, 32'hDEAD_BEEF, 1, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'hFFFF_FFFC, 32'd4, 1'b1, 1'b0};
      vecs[4] = '{1'b0, 32'hFFFF_FFFC, 0, 32'hCAFE_F00D, 0, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000, 32'd5, 1'b1, 1'b0};
      vecs[5] = '{1'b0, 32'h0000_0000, 0, 32'h0000_0013, 2, 1'b1, 32'h0000_0100, 1'b0, 32'h0000_0100, 32'd6, 1'b1, 1'b0};
      vecs[6] = '{1'b0, 32'h0000_0100, 1, 32'hA5A5_A5A5, 0, 1'b0, 32'h0000_0000, 1'b1, 32'h0000_0104, 32'd7, 1'b0, 1'b0};
      vecs[7] = '{1'b1, 32'h0000_0104, 0, 32'h5A5A_5A5A, 0, 1'b0, 32'h0000_0000, 1'b1, 32'h0000_0108, 32'd8, 1'b0, 1'b0};

      Reset         = 1'b0;
      start         = 1'b0;
      halt          = 1'b0;
      imem_ack      = 1'b0;
      imem_rdata    = 32'h0;
      instr_ready   = 1'b0;
      branch_taken  = 1'b0;
      branch_offset = 32'h0;

      // Reset state and idle behaviour without start.
      repeat (2) @(negedge clock);
      chk_reset_state("reset");
      Reset = 1'b1;
      @(negedge clock);
      chk("idle.no_req", imem_req, 1'b0);

      for (int i = 0; i < 8; i++) begin
         run_vec(vecs[i], $sformatf("vec%0d", i));
      end

      // IDLE after halt: a stray ack must not load or raise valid.
      imem_ack   = 1'b1;
      imem_rdata = 32'h1111_2222;
      @(negedge clock);
      imem_ack = 1'b0;
      @(negedge clock);
      chk("idle_ack.instr", instr, 32'h5A5A_5A5A);
      chk("idle_ack.valid", instr_valid, 1'b0);
      chk("idle_ack.req", imem_req, 1'b0);
      chk("idle_ack.pc", pc, 32'h0000_0108);
      $display("idle_ack instr=%h valid=%0d", instr, instr_valid);

      // Reset asserted mid-REQ acts before the next clock edge.
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      chk("rst_req.pre_req", imem_req, 1'b1);
      #2 Reset = 1'b0;
      #1 chk_reset_state("rst_req");
      @(negedge clock);
      Reset      = 1'b1;
      imem_ack   = 1'b1;
      imem_rdata = 32'h7777_8888;
      @(negedge clock);
      imem_ack = 1'b0;
      chk("rst_req.late_ack_valid", instr_valid, 1'b0);
      chk("rst_req.late_ack_instr", instr, 32'h0);
      chk("rst_req.late_ack_req", imem_req, 1'b0);
      $display("rst_req pc=%h instr=%h", pc, instr);

      // Reset asserted mid-ISSUE drops the offered instruction.
      start = 1'b1;
      @(negedge clock);
      start      = 1'b0;
      imem_ack   = 1'b1;
      imem_rdata = 32'h0000_0033;
      @(negedge clock);
      imem_ack = 1'b0;
      chk("rst_iss.pre_valid", instr_valid, 1'b1);
      #2 Reset = 1'b0;
      #1 chk_reset_state("rst_iss");
      @(negedge clock);
      Reset = 1'b1;
      @(negedge clock);
      chk("rst_iss.idle_req", imem_req, 1'b0);
      $display("rst_iss pc=%h valid=%0d", pc, instr_valid);

      // Misaligned branch target: pc 4 + 2 -> 6.
      t0 = '{1'b1, 32'h0000_0000, 0, 32'h0000_0013, 0, 1'b0, 32'h0, 1'b0, 32'h0000_0004, 32'd1, 1'b1, 1'b0};
      t1 = '{1'b0, 32'h0000_0004, 0, 32'h0000_0063, 0, 1'b1, 32'h2, 1'b0, 32'h0000_0006, 32'd2, !TRAP_EN, TRAP_EN};
      run_vec(t0, "trap0");
      run_vec(t1, "trap1");
      for (int k = 0; k < 3; k++) begin
         start = 1'b1;
         @(negedge clock);
         start = 1'b0;
         chk("trap_hold.req", imem_req, !TRAP_EN);
         chk("trap_hold.valid", instr_valid, 1'b0);
         chk("trap_hold.trap", trap, TRAP_EN);
         chk("trap_hold.pc", pc, 32'h0000_0006);
      end
      $display("trap_hold pc=%h trap=%0d req=%0d", pc, trap, imem_req);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pc_fetch_sequencer.md
PC_FETCH_SEQUENCER -- requirements
Module: pc_fetch_sequencer

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, sets the PC value loaded at reset.
REQ-002 Port clock, input, 1, is the single clock; all state updates occur on the rising edge.
REQ-003 Port Reset, input, 1, is the reset: asynchronous, active-low.
REQ-004 Port start, input, 1, is a one-cycle pulse that starts fetching from IDLE.
REQ-005 Port halt, input, 1, returns the block to IDLE after the current retire.
REQ-006 Port imem_req, output, 1, is the instruction-memory request.
REQ-007 Port imem_addr, output, 32, is the fetch address.
REQ-008 Port imem_ack, input, 1, marks read data valid.
REQ-009 Port imem_rdata, input, 32, is the fetched word.
REQ-010 Port instr_valid, output, 1, offers an instruction downstream.
REQ-011 Port instr, output, 32, is the held instruction word.
REQ-012 Port instr_ready, input, 1, is the downstream accept signal.
REQ-013 Port branch_taken, input, 1, is the branch decision for the retiring instruction.
REQ-014 Port branch_offset, input, 32, is the pre-shifted byte offset.
REQ-015 Port pc, output, 32, is the current PC.
REQ-016 Port instret, output, 32, is the retired-instruction count.
REQ-017 Port trap, output, 1, flags a misaligned-target trap.

Function
REQ-018 The FSM SHALL have states IDLE, REQ, ISSUE and TRAP.
REQ-019 IDLE: start=1 SHALL move to REQ next cycle; start is ignored in all other states.
REQ-020 REQ: imem_req=1 and imem_addr=pc SHALL be held every cycle until imem_ack=1.
REQ-021 On imem_ack in REQ, imem_rdata SHALL be latched into instr, instr_valid SHALL be 1 from the next cycle, and the FSM SHALL go to ISSUE (one-cycle latency from ack).
REQ-022 imem_ack outside REQ SHALL be ignored.
REQ-023 ISSUE: instr_valid and instr SHALL remain stable until instr_valid & instr_ready.
REQ-024 On the handshake cycle, pc SHALL load pc+branch_offset if branch_taken=1, else pc+4.
REQ-025 The next-PC arithmetic SHALL be modulo 2^32 (wrap, no overflow flag).
REQ-026 On the handshake cycle, instret SHALL increment, wrapping 32'hFFFF_FFFF -> 0.
REQ-027 On the handshake cycle, instr_valid SHALL clear.
REQ-028 After a handshake the FSM SHALL go to IDLE if halt=1 that cycle, else to REQ (back-to-back fetch).
REQ-029 branch_taken, branch_offset and halt SHALL be sampled only on handshake cycles.
REQ-030 pc SHALL change only on handshake cycles or reset.
REQ-031 imem_req and instr_valid SHALL never be 1 in the same cycle.

Reset
REQ-032 Reset=0 SHALL immediately force: state IDLE, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=0, instret=0, trap=0.
REQ-033 Reset asserted mid-REQ or mid-ISSUE SHALL abandon the transaction; a late imem_ack after release SHALL be ignored in IDLE.

Configuration
REQ-034 With macro PC_TRAP_EN defined, a computed next-PC with bits[1:0]!=0 SHALL load pc with that value, set trap=1, enter TRAP, and stay there (imem_req=0, instr_valid=0) until reset.
REQ-035 Without PC_TRAP_EN, the target SHALL be used as-is, trap SHALL be tied 0, and TRAP SHALL be unreachable.

Structure
REQ-036 Shared package pc_seq_pkg SHALL hold the FSM state enum, XLEN=32 and INSTR_BYTES=4.
REQ-037 Next-PC computation SHALL be a combinational sub-module pc_next_adder(pc, branch_taken, branch_offset -> next_pc).

Verification
REQ-038 Reset, start, ack after 3 wait cycles with rdata 32'h00500093, ready=1 -> instr=32'h00500093, pc 0 -> 4, instret=1.
REQ-039 pc=8, branch_taken=1, offset=32'hFFFF_FFF8 at handshake -> pc=0, next imem_addr=0.
REQ-040 pc=32'hFFFF_FFFC, no branch -> pc wraps to 0.
REQ-041 instr_ready held 0 for 5 cycles -> instr stable, pc unchanged, no imem_req.
REQ-042 Reset pulsed low while in REQ -> imem_req=0 at once, pc=RESET_PC; ack after release ignored.
REQ-043 With PC_TRAP_EN, offset=2 taken from pc=4 -> pc=6, trap=1, no further requests; without PC_TRAP_EN -> imem_addr=6, trap=0.
